multi_channel_clock_divider: RTL and testbench
==============================================

Name: multi_channel_clock_divider

Overview:
- Parametrised successor to the single-output fixed-ratio clock divider.
- Generates NUM_CH independent divided clocks. Each channel has a runtime-programmable divisor, a one-cycle tick pulse and a per-channel enable.
- Divisor writes go to a shadow register and take effect only at the channel's period boundary, so no runt pulses appear.
- Sits between the board clock and the real-time counter / display-scan logic; replaces hard-coded divide constants.

Parameters:
- NUM_CH, 4: number of independent divider channels (1..16).
- WIDTH, 32: divisor and counter width in bits.
- DEFAULT_DIV, 100_000_000: divisor loaded into every channel at reset. Must be >= 2 and < 2**WIDTH.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  NUM_CH  per-channel count enable.
- wr_en  input  1  divisor write strobe, one cycle.
- wr_ch  input  max(1,$clog2(NUM_CH))  channel select for the write.
- wr_div  input  WIDTH  new divisor value.
- div_clk  output  NUM_CH  divided clock per channel, registered.
- tick  output  NUM_CH  one-cycle pulse per channel at period start, registered.
- pending  output  NUM_CH  shadow divisor written but not yet applied.

Behaviour:
- Reset (async assert, sync release), per channel:
  - shadow = active = DEFAULT_DIV; count = DEFAULT_DIV-1
  - div_clk = 0; tick = 0; pending = 0
- Clamp: a written divisor of 0 or 1 is stored as 2. Minimum period is 2 cycles. No other range check.
- Write:
  - On a clk edge with wr_en=1 and wr_ch < NUM_CH: shadow[wr_ch] <= clamped wr_div; pending[wr_ch] <= 1.
  - wr_ch >= NUM_CH: write ignored, no state change.
  - Writes are accepted regardless of en.
  - Back-to-back writes to one channel: last write wins.
- Count, per channel with en=1, each edge:
  - Wrap (count == active-1):
    - count <= 0; tick <= 1; div_clk <= 1
    - If pending: active <= shadow and pending <= 0.
  - Otherwise:
    - count <= count+1; tick <= 0
    - div_clk <= 0 when count+1 == ceil(active/2); else hold.
- Waveform:
  - Period = active cycles; high ceil(active/2), low floor(active/2).
  - Example D=3: 1,1,0. D=2: 1,0.
  - tick is high exactly in the first high cycle of each period.
- Latency:
  - First enabled edge after reset is a wrap, so tick and div_clk rise 1 cycle after en goes high.
  - A new divisor is first used for the period beginning at the next wrap after the write.
- Simultaneous write and wrap on the same channel:
  - The wrap loads the shadow value as it was before that edge; the new write sets shadow and pending=1.
  - The new value applies at the following wrap.
- en=0: count, div_clk and active hold; tick forced to 0 next edge; pending still settable. On re-enable, counting resumes from the held count.
- Channels are fully independent; no cross-channel interaction except the shared write port.
- Reset mid-period: all state returns to reset values immediately, and pending writes are lost.

Optional Feature:
- Macro: CLKDIV_SYNC_RESTART_EN
- Defined:
  - Adds input port restart (1 bit).
  - On an edge with restart=1, every channel with en=1 performs a forced wrap regardless of count: count <= 0, tick <= 1, div_clk <= 1, active <= shadow, pending <= 0.
  - Channels with en=0 are unaffected.
  - restart takes priority over the normal count step; a write in the same cycle still updates shadow/pending, per the simultaneous write-and-wrap rule.
  - Used to phase-align all channels.
- Undefined: no restart port; channels free-run from reset only.

Test Plan (bench uses DEFAULT_DIV=4, NUM_CH=4, WIDTH=8):
- Reset then en=4'b0001 -> ch0 tick pulses on cycles 1,5,9; div_clk0 pattern 1,1,0,0 repeating; ch1..3 div_clk=0, tick=0.
- Write ch0 div=5 mid-period (count=1) -> pending0=1 until next wrap; the next period is still 4 cycles, then 5-cycle periods with pattern 1,1,1,0,0; pending0 clears at that wrap.
- Write ch2 div=0 and ch3 div=1, all en=1 -> both apply as divisor 2 after their wraps; div_clk toggles every cycle; tick on every other cycle.
- Write on the exact wrap cycle of ch1 with div=6 -> that wrap keeps divisor 4; the following period is 6 cycles; wr_ch=7 (NUM_CH=4, 2-bit wr_ch wraps to 3) and out-of-range checks with NUM_CH=3 -> ignored.
- Drop en0 for 3 cycles mid-high phase -> div_clk0 held high, tick0=0, count frozen; the period completes after re-enable with total enabled cycles = 4.
- Assert reset mid-period with pending=1 -> outputs go to 0 asynchronously; after release, divisor is 4 again and pending=0.
- (CLKDIV_SYNC_RESTART_EN) Offset channels, pulse restart -> all enabled channels tick in the same cycle and stay phase-aligned for equal divisors.

Source files
------------

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent runtime-programmable clock dividers whose divisor updates are deferred to period boundaries.
// Optional synchronous phase-align input enabled by defining CLKDIV_SYNC_RESTART_EN.
module multi_channel_clock_divider #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 100_000_000,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WIDTH-1:0]  wr_div,
`ifdef CLKDIV_SYNC_RESTART_EN
    input  logic              restart,
`endif
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_CNT = WIDTH'(DEFAULT_DIV - 1);

    logic             force_wrap;
    logic [WIDTH-1:0] wr_val;

`ifdef CLKDIV_SYNC_RESTART_EN
    assign force_wrap = restart;
`else
    assign force_wrap = 1'b0;
`endif

    // Divisors below 2 cannot produce a high and a low phase.
    assign wr_val = (wr_div < WIDTH'(2)) ? WIDTH'(2) : wr_div;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] count_q, count_d;
        logic [WIDTH-1:0] active_q, active_d;
        logic [WIDTH-1:0] shadow_q, shadow_d;
        logic [WIDTH-1:0] half;
        logic             pending_q, pending_d;
        logic             div_clk_q, div_clk_d;
        logic             tick_q, tick_d;
        logic             wrap;
        logic             wr_hit;

        assign half   = (active_q >> 1) + WIDTH'(active_q[0]);
        assign wrap   = (count_q == active_q - WIDTH'(1));
        assign wr_hit = wr_en && (int'(wr_ch) == i);

        always_comb begin
            count_d   = count_q;
            active_d  = active_q;
            shadow_d  = shadow_q;
            pending_d = pending_q;
            div_clk_d = div_clk_q;
            tick_d    = 1'b0;
            if (en[i]) begin
                if (force_wrap || wrap) begin
                    count_d   = '0;
                    tick_d    = 1'b1;
                    div_clk_d = 1'b1;
                    if (pending_q || force_wrap) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                    if (count_d == half) begin
                        div_clk_d = 1'b0;
                    end
                end
            end
            // A write on a wrap edge lands after the wrap consumed the old shadow.
            if (wr_hit) begin
                shadow_d  = wr_val;
                pending_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count_q   <= DEF_CNT;
                active_q  <= DEF_DIV;
                shadow_q  <= DEF_DIV;
                pending_q <= 1'b0;
                div_clk_q <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                count_q   <= count_d;
                active_q  <= active_d;
                shadow_q  <= shadow_d;
                pending_q <= pending_d;
                div_clk_q <= div_clk_d;
                tick_q    <= tick_d;
            end
        end

        assign div_clk[i] = div_clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pending_q;
    end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed bench for multi_channel_clock_divider: DEFAULT_DIV=4, NUM_CH=4, WIDTH=8,
// plus a 3-channel instance for out-of-range write selects.
module tb_multi_channel_clock_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic [3:0] div_clk, tick, pending;
`ifdef CLKDIV_SYNC_RESTART_EN
    logic       restart;
`endif

    logic [2:0] en3;
    logic       wr_en3;
    logic [1:0] wr_ch3;
    logic [2:0] div_clk3, tick3, pending3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_channel_clock_divider #(
        .NUM_CH(4), .WIDTH(8), .DEFAULT_DIV(4)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
`ifdef CLKDIV_SYNC_RESTART_EN
        .restart(restart),
`endif
        .div_clk(div_clk), .tick(tick), .pending(pending)
    );

    multi_channel_clock_divider #(
        .NUM_CH(3), .WIDTH(8), .DEFAULT_DIV(4)
    ) dut3 (
        .clk(clk), .reset(reset), .en(en3),
        .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_div(wr_div),
`ifdef CLKDIV_SYNC_RESTART_EN
        .restart(1'b0),
`endif
        .div_clk(div_clk3), .tick(tick3), .pending(pending3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        en     = '0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        en3    = '0;
        wr_en3 = 1'b0;
        wr_ch3 = '0;
`ifdef CLKDIV_SYNC_RESTART_EN
        restart = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        en     = '0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        en3    = '0;
        wr_en3 = 1'b0;
        wr_ch3 = '0;
`ifdef CLKDIV_SYNC_RESTART_EN
        restart = 1'b0;
`endif
        step();
        n_checks++;
        if ({div_clk, tick, pending} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outs: got %b exp 0", {div_clk, tick, pending});
        end
        n_checks++;
        if ({div_clk3, tick3, pending3} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_outs3: got %b exp 0", {div_clk3, tick3, pending3});
        end
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if ({div_clk, tick, pending} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b exp 0", {div_clk, tick, pending});
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp_dc, exp_tk;
        int p;
        apply_reset();
        en = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            step();
            p = (k - 1) % 4;
            exp_dc = {3'b000, p < 2};
            exp_tk = {3'b000, p == 0};
            n_checks++;
            if (div_clk !== exp_dc || tick !== exp_tk) begin
                n_fail++;
                $display("FAIL basic k=%0d: got dc=%b tk=%b exp dc=%b tk=%b",
                         k, div_clk, tick, exp_dc, exp_tk);
            end
        end
    endtask

    task automatic test_write();
        logic [11:0] tk_t = 12'h084;
        logic [11:0] dc_t = 12'h39C;
        logic [11:0] pd_t = 12'h003;
        logic [3:0]  e_dc, e_tk, e_pd;
        apply_reset();
        en = 4'b0001;
        step();
        step();
        wr_en  = 1'b1;
        wr_ch  = 2'd0;
        wr_div = 8'd5;
        for (int j = 0; j < 12; j++) begin
            step();
            wr_en = 1'b0;
            e_dc = {3'b000, dc_t[j]};
            e_tk = {3'b000, tk_t[j]};
            e_pd = {3'b000, pd_t[j]};
            n_checks++;
            if (div_clk !== e_dc || tick !== e_tk || pending !== e_pd) begin
                n_fail++;
                $display("FAIL write edge=%0d: got dc=%b tk=%b pd=%b exp dc=%b tk=%b pd=%b",
                         j + 3, div_clk, tick, pending, e_dc, e_tk, e_pd);
            end
        end
    endtask

    task automatic test_clamp();
        logic [3:0] e_dc, e_tk;
        logic       odd, lo;
        int p;
        apply_reset();
        wr_en  = 1'b1;
        wr_ch  = 2'd2;
        wr_div = 8'd0;
        step();
        wr_ch  = 2'd3;
        wr_div = 8'd1;
        step();
        wr_en = 1'b0;
        n_checks++;
        if (pending !== 4'b1100) begin
            n_fail++;
            $display("FAIL clamp_pending: got %b exp 1100", pending);
        end
        en = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            step();
            p    = (k - 1) % 4;
            odd  = (k % 2) == 1;
            lo   = p < 2;
            e_dc = {odd, odd, lo, lo};
            e_tk = {odd, odd, p == 0, p == 0};
            n_checks++;
            if (div_clk !== e_dc || tick !== e_tk || pending !== 4'b0000) begin
                n_fail++;
                $display("FAIL clamp k=%0d: got dc=%b tk=%b pd=%b exp dc=%b tk=%b pd=0000",
                         k, div_clk, tick, pending, e_dc, e_tk);
            end
        end
    endtask

    task automatic test_back_to_back_wrap_write();
        logic [11:0] tk_t = 12'h411;
        logic [11:0] dc_t = 12'hC73;
        logic [11:0] pd_t = 12'h00F;
        logic [2:0]  w7 = 3'd7;
        logic [3:0]  e_dc, e_tk, e_pd;
        apply_reset();
        en     = 4'b0010;
        wr_en  = 1'b1;
        wr_ch  = 2'd1;
        wr_div = 8'd6;
        for (int k = 1; k <= 12; k++) begin
            step();
            wr_en = 1'b0;
            e_dc = {2'b00, dc_t[k-1], 1'b0};
            e_tk = {2'b00, tk_t[k-1], 1'b0};
            e_pd = {2'b00, pd_t[k-1], 1'b0};
            n_checks++;
            if (div_clk !== e_dc || tick !== e_tk || pending !== e_pd) begin
                n_fail++;
                $display("FAIL wrapwr k=%0d: got dc=%b tk=%b pd=%b exp dc=%b tk=%b pd=%b",
                         k, div_clk, tick, pending, e_dc, e_tk, e_pd);
            end
        end
        wr_en  = 1'b1;
        wr_ch  = w7[1:0];
        wr_div = 8'd9;
        step();
        wr_en = 1'b0;
        n_checks++;
        if (pending !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrch7: got %b exp 1000", pending);
        end
        wr_en3 = 1'b1;
        wr_ch3 = 2'd3;
        step();
        n_checks++;
        if (pending3 !== 3'b000) begin
            n_fail++;
            $display("FAIL oor_ch3: got %b exp 000", pending3);
        end
        wr_ch3 = 2'd2;
        step();
        wr_en3 = 1'b0;
        n_checks++;
        if (pending3 !== 3'b100) begin
            n_fail++;
            $display("FAIL inrange_ch2: got %b exp 100", pending3);
        end
    endtask

    task automatic test_enable();
        logic [7:0] en_t = 8'hF1;
        logic [7:0] tk_t = 8'h81;
        logic [7:0] dc_t = 8'h9F;
        logic [3:0] e_dc, e_tk;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            en = {3'b000, en_t[k-1]};
            step();
            e_dc = {3'b000, dc_t[k-1]};
            e_tk = {3'b000, tk_t[k-1]};
            n_checks++;
            if (div_clk !== e_dc || tick !== e_tk) begin
                n_fail++;
                $display("FAIL enable k=%0d: got dc=%b tk=%b exp dc=%b tk=%b",
                         k, div_clk, tick, e_dc, e_tk);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] tk_t = 6'h11;
        logic [5:0] dc_t = 6'h33;
        logic [3:0] e_dc, e_tk;
        apply_reset();
        en     = 4'b0001;
        wr_en  = 1'b1;
        wr_ch  = 2'd0;
        wr_div = 8'd5;
        step();
        wr_en = 1'b0;
        n_checks++;
        if (pending !== 4'b0001 || div_clk !== 4'b0001) begin
            n_fail++;
            $display("FAIL pre_reset: got pd=%b dc=%b exp pd=0001 dc=0001", pending, div_clk);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({div_clk, tick, pending} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got %b exp 0", {div_clk, tick, pending});
        end
        step();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            e_dc = {3'b000, dc_t[k-1]};
            e_tk = {3'b000, tk_t[k-1]};
            n_checks++;
            if (div_clk !== e_dc || tick !== e_tk || pending !== 4'b0000) begin
                n_fail++;
                $display("FAIL post_reset k=%0d: got dc=%b tk=%b pd=%b exp dc=%b tk=%b pd=0000",
                         k, div_clk, tick, pending, e_dc, e_tk);
            end
        end
    endtask

`ifdef CLKDIV_SYNC_RESTART_EN
    task automatic test_restart();
        logic [3:0] e_v;
        int p;
        apply_reset();
        en = 4'b0001;
        step();
        step();
        en = 4'b0011;
        step();
        en = 4'b1111;
        step();
        n_checks++;
        if (tick !== 4'b1100) begin
            n_fail++;
            $display("FAIL offset_tick: got %b exp 1100", tick);
        end
        restart = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            restart = 1'b0;
            p   = (k - 1) % 4;
            e_v = {4{p < 2}};
            n_checks++;
            if (div_clk !== e_v || tick !== {4{p == 0}}) begin
                n_fail++;
                $display("FAIL restart k=%0d: got dc=%b tk=%b exp dc=%b tk=%b",
                         k, div_clk, tick, e_v, {4{p == 0}});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_write();
        test_clamp();
        test_back_to_back_wrap_write();
        test_enable();
        test_reset_mid();
`ifdef CLKDIV_SYNC_RESTART_EN
        test_restart();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
